// File: rtl/magnitude_search_controller.sv
// Binary-search controller that drives an external magnitude comparator and
// reports the matching value, or flags inconsistent comparator responses.
module magnitude_search_controller #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_greater,
    input  logic             equal,
    input  logic             b_greater,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH:0]   cmp_count
);

    typedef enum logic {
        IDLE,
        PROBE
    } state_t;

    localparam logic [WIDTH-1:0] MAX   = '1;
    localparam logic [WIDTH-1:0] G_ONE = WIDTH'(1);
    localparam logic [WIDTH:0]   C_ONE = (WIDTH + 1)'(1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo_n;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] guess_n;
    logic [WIDTH-1:0] result_n;
    logic [WIDTH:0]   count_n;
    logic [WIDTH:0]   sum;
    logic             busy_n;
    logic             done_n;
    logic             error_n;
    logic             one_hot;
    logic             fault;
    logic             terminate;

    // A probe that would push lo past hi means the comparator contradicted itself.
    assign one_hot   = ({a_greater, equal, b_greater} == 3'b100) ||
                       ({a_greater, equal, b_greater} == 3'b010) ||
                       ({a_greater, equal, b_greater} == 3'b001);
    assign fault     = !one_hot || (a_greater && (guess == hi)) || (b_greater && (guess == lo));
    assign terminate = fault || equal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = PROBE;
            PROBE:   if (terminate) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        lo_n     = lo;
        hi_n     = hi;
        guess_n  = guess;
        result_n = result;
        count_n  = cmp_count;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        error_n  = 1'b0;
        sum      = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    lo_n    = '0;
                    hi_n    = MAX;
                    guess_n = MAX >> 1;
                    count_n = '0;
                    busy_n  = 1'b1;
                end
            end
            PROBE: begin
                count_n = cmp_count + C_ONE;
                if (terminate) begin
                    result_n = guess;
                    done_n   = 1'b1;
                    error_n  = fault;
                end else begin
                    busy_n = 1'b1;
                    // Midpoint uses one extra bit so lo+hi cannot wrap.
                    if (a_greater) begin
                        lo_n = guess + G_ONE;
                        sum  = {1'b0, lo_n} + {1'b0, hi};
                    end else begin
                        hi_n = guess - G_ONE;
                        sum  = {1'b0, lo} + {1'b0, hi_n};
                    end
                    guess_n = WIDTH'(sum >> 1);
                end
            end
            default: begin
                busy_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo        <= '0;
            hi        <= '0;
            guess     <= '0;
            result    <= '0;
            cmp_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            lo        <= lo_n;
            hi        <= hi_n;
            guess     <= guess_n;
            result    <= result_n;
            cmp_count <= count_n;
            busy      <= busy_n;
            done      <= done_n;
            error     <= error_n;
        end
    end

endmodule
